// File: rtl/smg_pkg.sv
// Shared constants, state type and BCD helper for the seven-segment scan feeder.
package smg_pkg;

  localparam logic [3:0] KEY_BLANK = 4'd15;
  localparam logic [3:0] KEY_OVF   = 4'd10;
  localparam int         BIN_W     = 14;
  localparam int         MAX_VAL   = 9999;
  localparam int         BCD_W     = 16;

  typedef enum logic {
    ST_IDLE,
    ST_CONV
  } state_t;

  // Double-dabble correction: any nibble of 5 or more gets +3 before the shift.
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    res = bcd;
    for (int n = 0; n < 4; n++) begin
      if (bcd[n*4 +: 4] >= 4'd5) begin
        res[n*4 +: 4] = bcd[n*4 +: 4] + 4'd3;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter with a valid/ready style start and a one-cycle done strobe.
module bin2bcd_seq
  import smg_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [BIN_W-1:0] i_bin,
  input  logic             i_start,
  output logic             o_rdy,
  output logic [BCD_W-1:0] o_bcd,
  output logic             o_done
);

  localparam int         SHIFT_W  = BIN_W + BCD_W;
  localparam logic [3:0] CNT_LAST = 4'(BIN_W - 1);

  state_t               r_state;
  state_t               w_next_state;
  logic [SHIFT_W-1:0]   r_shift;
  logic [3:0]           r_cnt;
  logic [SHIFT_W-1:0]   w_adj;
  logic [SHIFT_W-1:0]   w_shifted;

  assign w_adj     = {dabble_adjust(r_shift[SHIFT_W-1 -: BCD_W]), r_shift[BIN_W-1:0]};
  assign w_shifted = {w_adj[SHIFT_W-2:0], 1'b0};
  // The final shift result goes straight out so the digit register loads on the last CONV edge.
  assign o_bcd     = w_shifted[SHIFT_W-1 -: BCD_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    o_rdy        = 1'b0;
    o_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_rdy = 1'b1;
        if (i_start) begin
          w_next_state = ST_CONV;
        end
      end
      ST_CONV: begin
        if (r_cnt == CNT_LAST) begin
          o_done       = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (r_state == ST_IDLE) begin
      if (i_start) begin
        r_shift <= {{BCD_W{1'b0}}, i_bin};
        r_cnt   <= '0;
      end
    end else begin
      r_shift <= w_shifted;
      r_cnt   <= r_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/smg_scan.sv
// Binary-to-display feeder: overflow check, digit register, scan divider and key mux
// around the sequential BCD converter.
module smg_scan
  import smg_pkg::*;
#(
  parameter int CLK_HZ  = 12_000_000,
  parameter int SCAN_HZ = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BIN_W-1:0] bin_in,
  input  logic             bin_vld,
  output logic             bin_rdy,
  input  logic             blank_en,
  output logic [1:0]       sel,
  output logic [3:0]       key
);

  localparam int DIV_RAW = CLK_HZ / SCAN_HZ;
  localparam int DIV     = (DIV_RAW < 2) ? 2 : DIV_RAW;
  localparam int DIV_W   = $clog2(DIV);

  logic             w_over;
  logic             w_start;
  logic [BCD_W-1:0] w_bcd;
  logic             w_done;
  logic [BCD_W-1:0] r_digits;
  logic             r_ovf;
  logic [DIV_W-1:0] r_div;
  logic [1:0]       r_sel;
  logic [BCD_W-1:0] w_upper;

  assign w_over  = (bin_in > BIN_W'(MAX_VAL));
  assign w_start = bin_vld && !w_over;

  bin2bcd_seq u_conv (
    .clk     (clk),
    .rst     (rst),
    .i_bin   (bin_in),
    .i_start (w_start),
    .o_rdy   (bin_rdy),
    .o_bcd   (w_bcd),
    .o_done  (w_done)
  );

  // The overflow flag drops only when fresh digits land, so the old display holds during CONV.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_digits <= '0;
      r_ovf    <= 1'b0;
    end else if (w_done) begin
      r_digits <= w_bcd;
      r_ovf    <= 1'b0;
    end else if (bin_vld && bin_rdy && w_over) begin
      r_ovf    <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div <= '0;
      r_sel <= 2'd0;
    end else if (r_div == DIV_W'(DIV - 1)) begin
      r_div <= '0;
      r_sel <= r_sel + 2'd1;
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  assign sel = r_sel;

  // Shifting the selected digit to the bottom leaves it and all higher digits in w_upper.
  assign w_upper = r_digits >> {r_sel, 2'b00};

  always_comb begin
    key = w_upper[3:0];
    if (r_ovf) begin
      key = KEY_OVF;
    end else if (blank_en && (r_sel != 2'd0) && (w_upper == '0)) begin
      key = KEY_BLANK;
    end
  end

endmodule

// File: tb/tb_smg_scan.sv
// Randomized self-checking bench for smg_scan with an arithmetic display model.
module tb_smg_scan;

  logic        clk;
  logic        rst;
  logic [13:0] bin_in;
  logic        bin_vld;
  logic        bin_rdy;
  logic        blank_en;
  logic [1:0]  sel;
  logic [3:0]  key;

  int checkCount = 0;
  int failCount  = 0;
  int cyc;
  int mVal;
  bit mOvf;

  localparam int DIV = 4;
  int pow10 [4] = '{1, 10, 100, 1000};

  smg_scan #(.CLK_HZ(4), .SCAN_HZ(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .bin_in   (bin_in),
    .bin_vld  (bin_vld),
    .bin_rdy  (bin_rdy),
    .blank_en (blank_en),
    .sel      (sel),
    .key      (key)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since reset release; the expected digit index follows from this alone.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic int expSel();
    return (cyc / DIV) % 4;
  endfunction

  function automatic int expKey(input int s);
    if (mOvf) return 10;
    if (blank_en && s > 0 && mVal < pow10[s]) return 15;
    return (mVal / pow10[s]) % 10;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic checkDisplay();
    checkOutput("sel", 32'(sel), 32'(expSel()));
    checkOutput("key", 32'(key), 32'(expKey(expSel())));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      checkDisplay();
    end
  endtask

  // Send one value; optionally pulse a stray 5555 or assert reset at a given CONV cycle.
  task automatic applyStimulus(input int v, input int glitchAt, input int resetAt);
    int n;
    int lowCycles;
    n = 0;
    while (!bin_rdy && n < 50) begin
      @(negedge clk);
      checkDisplay();
      n++;
    end
    checkOutput("rdyBeforeSend", 32'(bin_rdy), 32'd1);
    bin_in  = 14'(v);
    bin_vld = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bin_vld = 1'b0;
    bin_in  = 14'($urandom);
    if (v > 9999) begin
      mOvf = 1'b1;
      checkOutput("ovfRdy", 32'(bin_rdy), 32'd1);
      checkDisplay();
      return;
    end
    lowCycles = 0;
    while (lowCycles < 40) begin
      if (bin_rdy) break;
      lowCycles++;
      checkDisplay();
      if (lowCycles == glitchAt) begin
        bin_in  = 14'd5555;
        bin_vld = 1'b1;
      end
      if (lowCycles == resetAt) begin
        rst = 1'b1;
        #1;
        mVal = 0;
        mOvf = 1'b0;
        checkOutput("rstSel", 32'(sel), 32'd0);
        checkOutput("rstKey", 32'(key), 32'd0);
        checkOutput("rstRdy", 32'(bin_rdy), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      @(negedge clk);
      bin_vld = 1'b0;
    end
    checkOutput("rdyLowCycles", 32'(lowCycles), 32'd14);
    mVal = v;
    mOvf = 1'b0;
    checkDisplay();
  endtask

  initial begin
    int v;
    rst      = 1'b1;
    bin_in   = '0;
    bin_vld  = 1'b0;
    blank_en = 1'b1;
    mVal     = 0;
    mOvf     = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("resetRdy", 32'(bin_rdy), 32'd1);
    checkOutput("resetSel", 32'(sel), 32'd0);
    checkOutput("resetKey", 32'(key), 32'd0);
    rst = 1'b0;
    idle(20);

    blank_en = 1'b0;
    applyStimulus(1234, 0, 0);
    idle(16);

    blank_en = 1'b1;
    applyStimulus(7, 0, 0);
    idle(6);
    blank_en = 1'b0;
    idle(10);

    applyStimulus(10000, 0, 0);
    idle(8);
    applyStimulus(9999, 0, 0);
    idle(8);

    applyStimulus(4321, 5, 0);
    idle(16);

    applyStimulus(8888, 0, 7);
    idle(16);

    for (int i = 0; i < 40; i++) begin
      v = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10000, 16383))
                                      : int'($urandom_range(0, 9999));
      blank_en = 1'($urandom_range(0, 1));
      applyStimulus(v, 0, 0);
      idle(int'($urandom_range(0, 6)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
